// File: rtl/axi_burst_buffer.sv
// ---------------------------------------------------------------------------
// axi_burst_buffer
//
// Elastic beat buffer between the AXI read-data channel and the AXI write-data
// channel of the copy datapath. Read beats (with RLAST) are stored in order and
// re-presented as write beats (with WLAST). A count of complete bursts held
// lets the AW issuer launch a write only once a whole burst is buffered, so the
// W stream never stalls mid-burst.
//
// Ports
//   ACLK, ARESET          clock, synchronous active-high reset
//   s_RVALID/RDATA/RLAST  read beat in
//   s_RREADY              buffer can take a beat (low while full or in reset)
//   m_WVALID/WDATA/WLAST  head beat out (first-word-fall-through)
//   m_WSTRB               constant all ones
//   m_WREADY              write port takes the head beat
//   flush                 synchronous clear of all buffered state
//   level                 beats currently held
//   burst_cnt             complete bursts held (RLAST received, WLAST not popped)
//   burst_avail           burst_cnt != 0
//   len_err               sticky burst-length violation
// ---------------------------------------------------------------------------
module axi_burst_buffer #(
  parameter int DATA_W    = 64,
  parameter int DEPTH     = 32,
  parameter int BURST_LEN = 16,
  localparam int PW       = $clog2(DEPTH)
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  s_RVALID,
  input  logic [DATA_W-1:0]     s_RDATA,
  input  logic                  s_RLAST,
  output logic                  s_RREADY,
  output logic                  m_WVALID,
  output logic [DATA_W-1:0]     m_WDATA,
  output logic [DATA_W/8-1:0]   m_WSTRB,
  output logic                  m_WLAST,
  input  logic                  m_WREADY,
  input  logic                  flush,
  output logic [PW:0]           level,
  output logic [PW:0]           burst_cnt,
  output logic                  burst_avail,
  output logic                  len_err
);

  localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [PW:0] PTR_ONE  = 1;
  localparam logic [BW-1:0] IDX_ONE  = 1;
  localparam logic [BW-1:0] IDX_LAST = BW'(BURST_LEN - 1);

  logic [DATA_W:0] mem [DEPTH];
  logic [PW:0]     wr_ptr;
  logic [PW:0]     rd_ptr;
  logic [BW-1:0]   beat_idx;
  logic [DATA_W:0] head;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  logic            burst_in;
  logic            burst_out;
  logic            idx_at_last;

  // Extra pointer MSB distinguishes full from empty when the low bits match.
  assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign empty = (wr_ptr == rd_ptr);

  // No bypass: readiness depends on registered pointers only.
  assign s_RREADY = !full && !ARESET;
  assign m_WVALID = !empty && !ARESET;

  assign push = s_RVALID && s_RREADY;
  assign pop  = m_WVALID && m_WREADY;

  // Head read is combinational; contents when empty are don't-care.
  assign head    = mem[rd_ptr[PW-1:0]];
  assign m_WDATA = head[DATA_W-1:0];
  assign m_WLAST = head[DATA_W];
  assign m_WSTRB = '1;

  assign level       = wr_ptr - rd_ptr;
  assign burst_avail = (burst_cnt != '0);

  assign burst_in    = push && s_RLAST;
  assign burst_out   = pop && m_WLAST;
  assign idx_at_last = (beat_idx == IDX_LAST);

  // Storage is never cleared; a flushed cycle's beat is simply not written.
  always_ff @(posedge ACLK) begin
    if (push && !flush) begin
      mem[wr_ptr[PW-1:0]] <= {s_RLAST, s_RDATA};
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET || flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      burst_cnt <= '0;
      beat_idx  <= '0;
      len_err   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end

      case ({burst_in, burst_out})
        2'b10:   burst_cnt <= burst_cnt + PTR_ONE;
        2'b01:   burst_cnt <= burst_cnt - PTR_ONE;
        default: burst_cnt <= burst_cnt;
      endcase

      // A mismatch between RLAST and the expected last index flags an error;
      // either way the counter returns to 0 so the next beat starts a burst.
      if (push) begin
        if (s_RLAST || idx_at_last) begin
          beat_idx <= '0;
        end else begin
          beat_idx <= beat_idx + IDX_ONE;
        end
        if (s_RLAST != idx_at_last) begin
          len_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_axi_burst_buffer.sv
module tb_axi_burst_buffer;

  localparam int DATA_W    = 64;
  localparam int DEPTH     = 32;
  localparam int BURST_LEN = 16;
  localparam int PW        = $clog2(DEPTH);

  bit                  ACLK;
  logic                ARESET;
  logic                s_RVALID;
  logic [DATA_W-1:0]   s_RDATA;
  logic                s_RLAST;
  logic                s_RREADY;
  logic                m_WVALID;
  logic [DATA_W-1:0]   m_WDATA;
  logic [DATA_W/8-1:0] m_WSTRB;
  logic                m_WLAST;
  logic                m_WREADY;
  logic                flush;
  logic [PW:0]         level;
  logic [PW:0]         burst_cnt;
  logic                burst_avail;
  logic                len_err;

  axi_burst_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .BURST_LEN(BURST_LEN)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .s_RVALID(s_RVALID), .s_RDATA(s_RDATA), .s_RLAST(s_RLAST), .s_RREADY(s_RREADY),
    .m_WVALID(m_WVALID), .m_WDATA(m_WDATA), .m_WSTRB(m_WSTRB), .m_WLAST(m_WLAST),
    .m_WREADY(m_WREADY), .flush(flush), .level(level), .burst_cnt(burst_cnt),
    .burst_avail(burst_avail), .len_err(len_err)
  );

  always #5 ACLK = ~ACLK;

  int compared;
  int mismatched;
  bit run_chk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: ordered queue of {last, data}, plus the read-side beat
  // position and sticky error, all advanced by the rules at each rising edge.
  logic [DATA_W:0] mq[$];
  int              m_idx;
  bit              m_err;

  function automatic int m_bursts();
    int n = 0;
    logic [DATA_W:0] e;
    foreach (mq[i]) begin
      e = mq[i];
      if (e[DATA_W]) n++;
    end
    return n;
  endfunction

  always @(posedge ACLK) begin
    bit pu, po;
    if (ARESET || flush) begin
      mq.delete();
      m_idx = 0;
      m_err = 0;
    end else begin
      pu = s_RVALID && (mq.size() < DEPTH);
      po = m_WREADY && (mq.size() > 0);
      if (po) void'(mq.pop_front());
      if (pu) begin
        mq.push_back({s_RLAST, s_RDATA});
        if (s_RLAST) begin
          if (m_idx != BURST_LEN - 1) m_err = 1;
          m_idx = 0;
        end else if (m_idx == BURST_LEN - 1) begin
          m_err = 1;
          m_idx = 0;
        end else begin
          m_idx++;
        end
      end
    end
  end

  always @(negedge ACLK) begin
    logic [DATA_W:0] h;
    if (run_chk) begin
      chk("s_RREADY", s_RREADY, !ARESET && (mq.size() < DEPTH));
      chk("m_WVALID", m_WVALID, !ARESET && (mq.size() > 0));
      chk("level", level, mq.size());
      chk("burst_cnt", burst_cnt, m_bursts());
      chk("burst_avail", burst_avail, m_bursts() != 0);
      chk("len_err", len_err, m_err);
      chk("m_WSTRB", m_WSTRB, 8'hFF);
      if (!ARESET && mq.size() > 0) begin
        h = mq[0];
        chk("m_WDATA", m_WDATA, h[DATA_W-1:0]);
        chk("m_WLAST", m_WLAST, h[DATA_W]);
      end
    end
  end

  task automatic drv(input bit v, input logic [63:0] d, input bit l, input bit wr,
                     input bit fl, input bit rs);
    s_RVALID = v;
    s_RDATA  = d;
    s_RLAST  = l;
    m_WREADY = wr;
    flush    = fl;
    ARESET   = rs;
    @(posedge ACLK);
    #1;
  endtask

  task automatic idle(input bit wr);
    drv(0, 0, 0, wr, 0, 0);
  endtask

  initial begin
    int rbi;
    bit v, wr, l, fl, rs;
    int wr_pct;

    compared = 0;
    mismatched = 0;
    run_chk = 0;
    drv(0, 0, 0, 0, 0, 1);
    run_chk = 1;
    chk("rst_rready", s_RREADY, 0);
    chk("rst_wvalid", m_WVALID, 0);
    drv(0, 0, 0, 0, 0, 1);
    ARESET = 0;
    #1;
    chk("post_rst_rready", s_RREADY, 1);
    chk("post_rst_wvalid", m_WVALID, 0);
    chk("post_rst_level", level, 0);
    chk("post_rst_avail", burst_avail, 0);
    chk("post_rst_err", len_err, 0);
    chk("post_rst_strb", m_WSTRB, 8'hFF);

    // Single burst, streaming through.
    for (int i = 0; i < 16; i++) drv(1, i, i == 15, 1, 0, 0);
    chk("single_avail_up", burst_avail, 1);
    chk("single_head_last", m_WLAST, 1);
    chk("single_head_data", m_WDATA, 15);
    idle(1);
    chk("single_avail_down", burst_avail, 0);
    chk("single_level", level, 0);
    chk("single_err", len_err, 0);

    // Fill with two bursts, then a held 33rd beat.
    for (int i = 0; i < 32; i++) drv(1, 100 + i, (i % 16) == 15, 0, 0, 0);
    chk("fill_level", level, 32);
    chk("fill_rready", s_RREADY, 0);
    chk("fill_bursts", burst_cnt, 2);
    drv(1, 999, 0, 0, 0, 0);
    chk("fill_held_level", level, 32);
    drv(1, 999, 0, 1, 0, 0);
    chk("fill_pop_level", level, 31);
    chk("fill_pop_rready", s_RREADY, 1);
    drv(1, 999, 0, 0, 0, 0);
    chk("fill_b33_level", level, 32);
    for (int i = 0; i < 34; i++) idle(1);
    chk("fill_drained", level, 0);
    drv(0, 0, 0, 0, 1, 0);

    // Push+pop at level 5.
    for (int i = 0; i < 5; i++) drv(1, 200 + i, 0, 0, 0, 0);
    chk("lvl5", level, 5);
    drv(1, 205, 0, 1, 0, 0);
    chk("lvl5_pushpop", level, 5);
    drv(0, 0, 0, 0, 1, 0);

    // RLAST push coinciding with WLAST pop.
    for (int i = 0; i < 16; i++) drv(1, 300 + i, i == 15, 0, 0, 0);
    for (int i = 0; i < 15; i++) drv(1, 400 + i, 0, 1, 0, 0);
    chk("coinc_before", burst_cnt, 1);
    drv(1, 415, 1, 1, 0, 0);
    chk("coinc_bursts", burst_cnt, 1);
    chk("coinc_level", level, 16);
    for (int i = 0; i < 17; i++) idle(1);

    // Early RLAST on index 9, then a correct burst.
    drv(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 10; i++) drv(1, 500 + i, i == 9, 1, 0, 0);
    chk("early_last_err", len_err, 1);
    for (int i = 0; i < 16; i++) drv(1, 600 + i, i == 15, 1, 0, 0);
    chk("err_sticky", len_err, 1);
    drv(0, 0, 0, 1, 1, 0);
    chk("err_flushed", len_err, 0);

    // Missing RLAST on beat 15.
    for (int i = 0; i < 15; i++) drv(1, 700 + i, 0, 1, 0, 0);
    chk("no_last_pre", len_err, 0);
    drv(1, 715, 0, 1, 0, 0);
    chk("no_last_err", len_err, 1);
    drv(0, 0, 0, 1, 1, 0);

    // Flush at level 7 together with a push and a pop.
    for (int i = 0; i < 7; i++) drv(1, 800 + i, i == 2, 0, 0, 0);
    chk("pre_flush_level", level, 7);
    drv(1, 807, 0, 1, 1, 0);
    chk("flush_level", level, 0);
    chk("flush_wvalid", m_WVALID, 0);
    chk("flush_bursts", burst_cnt, 0);
    chk("flush_err", len_err, 0);

    // One-cycle reset mid-burst.
    for (int i = 0; i < 10; i++) drv(1, 900 + i, 0, 0, 0, 0);
    chk("pre_rst_level", level, 10);
    s_RVALID = 1;
    ARESET = 1;
    #1;
    chk("midrst_rready", s_RREADY, 0);
    chk("midrst_wvalid", m_WVALID, 0);
    @(posedge ACLK);
    #1;
    ARESET = 0;
    s_RVALID = 0;
    #1;
    chk("midrst_level", level, 0);
    for (int i = 0; i < 16; i++) drv(1, 950 + i, i == 15, 1, 0, 0);
    idle(1);
    chk("midrst_burst_err", len_err, 0);
    chk("midrst_burst_level", level, 0);

    // Randomized traffic.
    wr_pct = 70;
    for (int c = 0; c < 4000; c++) begin
      if (c % 250 == 0) wr_pct = $urandom_range(10, 100);
      v  = ($urandom_range(0, 99) < 80);
      wr = ($urandom_range(0, 99) < wr_pct);
      rbi = m_idx;
      l  = (rbi == BURST_LEN - 1) ? ($urandom_range(0, 49) != 0) : ($urandom_range(0, 59) == 0);
      fl = ($urandom_range(0, 599) == 0);
      rs = ($urandom_range(0, 799) == 0);
      drv(v, {$urandom, $urandom}, l, wr, fl, rs);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
